// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART transmit and receive blocks.
//   parity_t     line parity mode (encoding 3 is treated as no parity)
//   tx_state_t   frame sequencing states of the transmitter
//   calc_parity  parity bit for a data word under a given mode
package uart_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // The data word is zero-extended to MAX_DATA_WIDTH, which leaves its XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input parity_t mode);
    logic par_s;
    if (mode == PAR_ODD) begin
      par_s = ~^data;
    end else begin
      par_s = ^data;
    end
    return par_s;
  endfunction

  function automatic logic parity_enabled(input parity_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/axis_if.sv
// axis_if: minimal AXI-Stream bundle (tdata/tvalid/tready).
//   slave modport : receives tdata/tvalid, drives tready
//   master modport: drives tdata/tvalid, receives tready
interface axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport slave  (input tdata, input tvalid, output tready);
  modport master (output tdata, output tvalid, input tready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable bit-period counter.
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   div            : clocks per bit (0 behaves as 1)
//   enable         : count while high, hold while low
//   clear          : synchronously force the count to zero
//   bit_end        : one-clock tick on the last clock of each bit period
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 enable,
  input  logic                 clear,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] div_last_s;

  // Last count value of a bit; a divisor of 0 collapses to a 1-clock bit.
  always_comb begin
    div_last_s = {DIV_WIDTH{1'b0}};
    if (div == {DIV_WIDTH{1'b0}}) begin
      div_last_s = {DIV_WIDTH{1'b0}};
    end else begin
      div_last_s = div - DIV_WIDTH'(1);
    end
  end

  assign bit_end = enable && (cnt_r == div_last_s);

  // Bit-period counter, wraps to zero on each bit end.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (clear) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (enable) begin
      if (bit_end) begin
        cnt_r <= {DIV_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + DIV_WIDTH'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/axis_uart_tx_cfg.sv
// axis_uart_tx_cfg: AXI-Stream to UART transmitter with per-frame configuration.
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   baud_div_i     : clocks per bit, latched with each word (0 behaves as 1)
//   parity_i       : none / even / odd, latched with each word
//   stop2_i        : two stop bits when high, latched with each word
//   busy_o         : high while a frame is on the line (registered)
//   tx_o           : serial line, idle high (registered)
//   s_axis         : word input; tready is high only in IDLE
module axis_uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  parity_t              parity_i,
  input  logic                 stop2_i,
  output logic                 busy_o,
  output logic                 tx_o,
  axis_if.slave                s_axis
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_r, state_next_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_next_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
  logic [DIV_WIDTH-1:0]  div_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  stop2_r;
  logic                  tx_r, tx_next_s;
  logic                  busy_r;
  logic                  handshake_s;
  logic                  bit_end_s;
  logic [CNT_W-1:0]      last_stop_s;

  assign s_axis.tready = (state_r == IDLE);
  assign handshake_s   = s_axis.tvalid && (state_r == IDLE);
  assign last_stop_s   = stop2_r ? CNT_ONE : CNT_ZERO;
  assign tx_o          = tx_r;
  assign busy_o        = busy_r;

  // The counter idles at zero so a new frame always starts on a full bit.
  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .div     (div_r),
    .enable  (state_r != IDLE),
    .clear   (state_r == IDLE),
    .bit_end (bit_end_s)
  );

  // Next-state, bit index and shift register sequencing.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          state_next_s   = START;
          bit_cnt_next_s = CNT_ZERO;
          shift_next_s   = s_axis.tdata;
        end else begin
          state_next_s   = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_next_s   = DATA;
          bit_cnt_next_s = CNT_ZERO;
        end else begin
          state_next_s   = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_next_s = shift_r >> 1;
          if (bit_cnt_r == LAST_DATA) begin
            bit_cnt_next_s = CNT_ZERO;
            state_next_s   = par_en_r ? PARITY : STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_next_s   = STOP;
          bit_cnt_next_s = CNT_ZERO;
        end else begin
          state_next_s   = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (bit_cnt_r == last_stop_s) begin
            state_next_s   = IDLE;
            bit_cnt_next_s = CNT_ZERO;
          end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s   = IDLE;
        bit_cnt_next_s = CNT_ZERO;
      end
    endcase
  end

  // Line level for the next clock, derived from where the sequencer is heading
  // so tx_o can be a plain register without a cycle of lag.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      PARITY:  tx_next_s = par_bit_r;
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  // Sequencer state and line output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r   <= IDLE;
      bit_cnt_r <= CNT_ZERO;
      shift_r   <= {DATA_WIDTH{1'b0}};
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
      tx_r      <= tx_next_s;
      busy_r    <= (state_next_s != IDLE);
    end
  end

  // Per-frame configuration, captured only on the handshake.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_r     <= {DIV_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
    end else if (handshake_s) begin
      div_r     <= baud_div_i;
      par_en_r  <= parity_enabled(parity_i);
      par_bit_r <= calc_parity(MAX_DATA_WIDTH'(s_axis.tdata), parity_i);
      stop2_r   <= stop2_i;
    end else begin
      div_r     <= div_r;
      par_en_r  <= par_en_r;
      par_bit_r <= par_bit_r;
      stop2_r   <= stop2_r;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_cfg.sv
// tb_axis_uart_tx_cfg: directed and randomized frames checked cycle by cycle
// against a bit-list model of the UART frame.
module tb_axis_uart_tx_cfg;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           clk      = 1'b0;
  logic           arstn    = 1'b0;
  logic [DVW-1:0] baud_div = 16'd1;
  parity_t        parity   = PAR_NONE;
  logic           stop2    = 1'b0;
  logic           busy;
  logic           tx;

  int checks = 0;
  int errors = 0;

  axis_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_uart_tx_cfg #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DVW)
  ) dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .baud_div_i (baud_div),
    .parity_i   (parity),
    .stop2_i    (stop2),
    .busy_o     (busy),
    .tx_o       (tx),
    .s_axis     (s_axis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word with the given configuration, then check every clock of
  // the frame plus the idle clock after it. Called and returning on a negedge.
  task automatic run_frame(input logic [7:0] d, input int div, input int par,
                           input bit s2, input bit hold_valid, input bit wiggle);
    bit q[$];
    int eff;
    int total;
    int waited;
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    baud_div      = 16'(div);
    parity        = parity_t'(2'(par));
    stop2         = s2;
    waited = 0;
    while (s_axis.tready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("handshake_ready", 32'(s_axis.tready), 32'd1);
    @(posedge clk);
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (par == 1) q.push_back(^d);
    else if (par == 2) q.push_back(~^d);
    q.push_back(1'b1);
    if (s2) q.push_back(1'b1);
    eff   = (div == 0) ? 1 : div;
    total = q.size() * eff;
    @(negedge clk);
    if (!hold_valid) s_axis.tvalid = 1'b0;
    s_axis.tdata = 8'($urandom);
    if (wiggle) begin
      baud_div = 16'($urandom_range(1, 50));
      parity   = parity_t'(2'($urandom_range(0, 3)));
      stop2    = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < total; c++) begin
      chk("tx_bit", 32'(tx), 32'(q[c / eff]));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("tready_in_frame", 32'(s_axis.tready), 32'd0);
      @(negedge clk);
    end
    chk("tx_after_frame", 32'(tx), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("tready_after_frame", 32'(s_axis.tready), 32'd1);
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    arstn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(s_axis.tready), 32'd1);

    // tvalid held low: line stays idle
    for (int i = 0; i < 20; i++) begin
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // 0x55 at div 234, no parity, one stop
    run_frame(8'h55, 234, 0, 1'b0, 1'b0, 1'b0);

    // Even then odd parity on 0x07
    run_frame(8'h07, 10, 1, 1'b0, 1'b0, 1'b0);
    run_frame(8'h07, 10, 2, 1'b0, 1'b0, 1'b0);

    // Back-to-back with tvalid held, two stop bits
    run_frame(8'hA5, 4, 0, 1'b1, 1'b1, 1'b0);
    run_frame(8'h3C, 4, 0, 1'b1, 1'b1, 1'b0);
    run_frame(8'hF0, 4, 0, 1'b1, 1'b0, 1'b0);

    // Configuration change mid-frame, then a frame with new settings
    run_frame(8'h9B, 12, 2, 1'b1, 1'b0, 1'b1);
    run_frame(8'h9B, 3, 1, 1'b0, 1'b0, 1'b0);

    // Reset in DATA bit 3 of 0x52 (bit 3 is 0, so the abort is visible)
    s_axis.tdata  = 8'h52;
    s_axis.tvalid = 1'b1;
    baud_div      = 16'd8;
    parity        = PAR_NONE;
    stop2         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    repeat (35) @(negedge clk);
    chk("pre_abort_tx", 32'(tx), 32'd0);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 arstn = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(s_axis.tready), 32'd1);
    run_frame(8'hA3, 6, 1, 1'b0, 1'b0, 1'b0);

    // Divisor 0 and 1: one clock per bit
    run_frame(8'hFF, 0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(8'hFF, 1, 0, 1'b0, 1'b0, 1'b0);

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      run_frame(8'($urandom), $urandom_range(0, 7), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
    s_axis.tvalid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
